ram_bus_arbiter: RTL and testbench
==================================

Name: ram_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the req/we/addr/be/wdata/ack/resp/rdata memory bus.
- Shares one port of the dual-port RAM wrapper between two requesters, e.g. instruction fetch plus a DMA/debug master on the same RAM port.
- Round-robin grant, slave ack-stall propagation, in-order read-response routing through an ID FIFO.

Parameters:
- RESP_DEPTH, 4, maximum reads accepted by the slave but not yet responded (ID FIFO depth, power of 2, ≥2)
- ADDR_W, 32, address width
- DATA_W, 32, data width

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- m0_req_i  in  1  master0 request
- m0_we_i  in  1  master0 write enable
- m0_addr_bi  in  ADDR_W  master0 byte address
- m0_be_bi  in  4  master0 byte enables
- m0_wdata_bi  in  DATA_W  master0 write data
- m0_ack_o  out  1  master0 request accepted this cycle
- m0_resp_o  out  1  master0 read data valid
- m0_rdata_bo  out  DATA_W  master0 read data
- m1_*  (same eight signals as m0_*)  master1
- s_req_o  out  1  slave request
- s_we_o  out  1  slave write enable
- s_addr_bo  out  ADDR_W  slave address
- s_be_bo  out  4  slave byte enables
- s_wdata_bo  out  DATA_W  slave write data
- s_ack_i  in  1  slave accepted; may be 0 while slave stalls, e.g. fractional-write writeback
- s_resp_i  in  1  slave read data valid
- s_rdata_bi  in  DATA_W  slave read data
- err_o  out  1  sticky: response arrived with empty ID FIFO

Behaviour:
- Reset (rst_i=0, async):
  - prio pointer = master0
  - FIFO empty, count=0
  - err_o=0
  - all outputs 0
- Eligibility:
  - master eligible = req_i & !(we_i==0 & fifo_full).
  - fifo_full = (count==RESP_DEPTH); a same-cycle pop does not unblock.
- Grant (combinational, zero latency):
  - one eligible master → it wins
  - both eligible → master named by prio wins
  - none → s_req_o=0
- Slave drive:
  - s_req_o=1; s_we/addr/be/wdata = winner's signals, unmodified
  - no winner → slave data outputs are 0
- Ack:
  - mX_ack_o = s_ack_i & (winner==X); the loser's ack is 0.
  - Master holds req and payload until acked.
- Priority update:
  - on accepted transfer (s_req_o & s_ack_i), prio ← other master than the winner
  - otherwise unchanged, so a slave stall keeps the same winner next cycle if it still requests
- ID FIFO push: on an accepted read (we=0), push winner ID.
- Response routing:
  - on s_resp_i with FIFO non-empty, pop head ID H
  - mH_resp_o=1, mH_rdata_bo=s_rdata_bi, combinational
  - other master: resp 0, rdata 0
- Spurious response: s_resp_i with FIFO empty → dropped (no master resp), err_o←1 (cleared only by reset).
- Simultaneous push and pop: both happen; count unchanged; head and tail pointers both advance, wrapping mod RESP_DEPTH.
- Writes produce no response and no FIFO entry.
- Starvation: a continuously requesting master is granted within 2 accepted transfers.
- Reset mid-operation: FIFO cleared; any in-flight response after reset → err_o=1.

Decomposition:
- Shared package holds:
  - master ID constants (MID_0=0, MID_1=1)
  - bus field widths (BE_W=4)
- Natural sub-module: ram_bus_id_fifo. Synchronous FIFO (1-bit data, RESP_DEPTH) with push, pop, full, empty and head outputs; async active-low reset.
- Arbiter top holds:
  - prio register
  - grant mux
  - err flag

Test Plan:
- Both masters read continuously; slave acks every cycle, resp 1 cycle later.
  - Grants alternate m0,m1,m0,m1.
  - Each master receives only its own rdata, in order (m0 addr 0x10 → data 0xAAAA0001, m1 addr 0x20 → 0xBBBB0002).
- m0 write be=4'b0001 addr 0x3; slave holds s_ack_i=0 for 1 cycle.
  - m0_ack_o=0 then 1; m1 (also requesting) is not granted until after m0's accept.
  - No FIFO entry.
- Slave never responds; m0 issues 5 reads with RESP_DEPTH=4.
  - 4 acks, then m0_ack_o=0.
  - m1 write still granted.
  - After one s_resp_i, the 5th read is acked the following cycle.
- Same-cycle read accept and response with count=2 → count stays 2; routing order preserved.
- s_resp_i pulse with empty FIFO → no mX_resp_o; err_o=1 and stays 1 until rst_i=0.
- Assert rst_i=0 asynchronously mid-burst → outputs 0 immediately; after release, first contested grant goes to m0.

Source files
------------

// File: rtl/ram_bus_arbiter_pkg.sv
// Shared definitions for the two-master RAM bus arbiter.
//   MID_0 / MID_1 : master identifiers, also the payload stored in the ID FIFO
//   BE_W          : byte-enable width of the memory bus
package ram_bus_arbiter_pkg;

    localparam int   BE_W  = 4;
    localparam logic MID_0 = 1'b0;
    localparam logic MID_1 = 1'b1;

    function automatic logic other_mid(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/ram_bus_id_fifo.sv
// Read-response ID FIFO: remembers which master issued each accepted read
// so that in-order slave responses can be routed back.
//   clk_i, rst_i  : clock, async active-low reset
//   push_i, id_i  : enqueue one master ID
//   pop_i         : dequeue the head entry
//   full_o        : DEPTH entries held
//   empty_o       : no entries held
//   head_o        : ID at the head (valid when !empty_o)
module ram_bus_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic push_i,
    input  logic id_i,
    input  logic pop_i,
    output logic full_o,
    output logic empty_o,
    output logic head_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        // A full FIFO never takes a push, even with a same-cycle pop.
        do_push  = push_i & ~full_o;
        do_pop   = pop_i & ~empty_o;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = id_i;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the req/ack/resp memory bus.
//   clk_i, rst_i         : clock, async active-low reset
//   m0_* / m1_*          : master request ports (req/we/addr/be/wdata in,
//                          ack/resp/rdata out)
//   s_*                  : slave port (req/we/addr/be/wdata out,
//                          ack/resp/rdata in)
//   err_o                : sticky, a response arrived with no read pending
// Grant is combinational; reads are tracked in an ID FIFO so responses are
// returned to the master that issued them, in order.
module ram_bus_arbiter
    import ram_bus_arbiter_pkg::*;
#(
    parameter int RESP_DEPTH = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_bi,
    input  logic [BE_W-1:0]   m0_be_bi,
    input  logic [DATA_W-1:0] m0_wdata_bi,
    output logic              m0_ack_o,
    output logic              m0_resp_o,
    output logic [DATA_W-1:0] m0_rdata_bo,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_bi,
    input  logic [BE_W-1:0]   m1_be_bi,
    input  logic [DATA_W-1:0] m1_wdata_bi,
    output logic              m1_ack_o,
    output logic              m1_resp_o,
    output logic [DATA_W-1:0] m1_rdata_bo,
    output logic              s_req_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_addr_bo,
    output logic [BE_W-1:0]   s_be_bo,
    output logic [DATA_W-1:0] s_wdata_bo,
    input  logic              s_ack_i,
    input  logic              s_resp_i,
    input  logic [DATA_W-1:0] s_rdata_bi,
    output logic              err_o
);

    logic prio_q, prio_d;
    logic err_q, err_d;
    logic fifo_full, fifo_empty, fifo_head;
    logic m0_elig, m1_elig, grant_vld, winner;
    logic accept, push, pop;

    always_comb begin
        // Gating with rst_i forces every bus output low while reset is held,
        // without waiting for a clock edge.
        m0_elig   = rst_i & m0_req_i & (m0_we_i | ~fifo_full);
        m1_elig   = rst_i & m1_req_i & (m1_we_i | ~fifo_full);
        grant_vld = m0_elig | m1_elig;

        if (m0_elig & m1_elig) begin
            winner = prio_q;
        end else if (m1_elig) begin
            winner = MID_1;
        end else begin
            winner = MID_0;
        end

        s_req_o    = grant_vld;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        if (grant_vld) begin
            if (winner == MID_1) begin
                s_we_o     = m1_we_i;
                s_addr_bo  = m1_addr_bi;
                s_be_bo    = m1_be_bi;
                s_wdata_bo = m1_wdata_bi;
            end else begin
                s_we_o     = m0_we_i;
                s_addr_bo  = m0_addr_bi;
                s_be_bo    = m0_be_bi;
                s_wdata_bo = m0_wdata_bi;
            end
        end

        accept   = grant_vld & s_ack_i;
        m0_ack_o = accept & (winner == MID_0);
        m1_ack_o = accept & (winner == MID_1);
        push     = accept & ~s_we_o;

        pop         = s_resp_i & ~fifo_empty;
        m0_resp_o   = pop & (fifo_head == MID_0);
        m1_resp_o   = pop & (fifo_head == MID_1);
        m0_rdata_bo = m0_resp_o ? s_rdata_bi : '0;
        m1_rdata_bo = m1_resp_o ? s_rdata_bi : '0;

        // A stalled transfer leaves prio alone so the same master keeps the bus.
        prio_d = accept ? other_mid(winner) : prio_q;
        err_d  = err_q | (s_resp_i & fifo_empty);
    end

    assign err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            prio_q <= MID_0;
            err_q  <= 1'b0;
        end else begin
            prio_q <= prio_d;
            err_q  <= err_d;
        end
    end

    ram_bus_id_fifo #(
        .DEPTH (RESP_DEPTH)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .id_i    (winner),
        .pop_i   (pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

    localparam int RESP_DEPTH = 4;
    localparam logic [31:0] DATA_M0 = 32'hAAAA_0001;
    localparam logic [31:0] DATA_M1 = 32'hBBBB_0002;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_req, m_we;
    logic [31:0] m_addr [2];
    logic [3:0]  m_be [2];
    logic [31:0] m_wdata [2];
    logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
    logic [31:0] m0_rdata_bo, m1_rdata_bo;
    logic        s_req_o, s_we_o;
    logic [31:0] s_addr_bo, s_wdata_bo;
    logic [3:0]  s_be_bo;
    logic        s_ack, s_resp;
    logic [31:0] s_rdata;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ram_bus_arbiter #(.RESP_DEPTH(RESP_DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m0_req_i(m_req[0]), .m0_we_i(m_we[0]), .m0_addr_bi(m_addr[0]),
        .m0_be_bi(m_be[0]), .m0_wdata_bi(m_wdata[0]),
        .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
        .m1_req_i(m_req[1]), .m1_we_i(m_we[1]), .m1_addr_bi(m_addr[1]),
        .m1_be_bi(m_be[1]), .m1_wdata_bi(m_wdata[1]),
        .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
        .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo),
        .s_be_bo(s_be_bo), .s_wdata_bo(s_wdata_bo),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
        .err_o(err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic set_idle();
        m_req = '0; m_we = '0;
        for (int k = 0; k < 2; k++) begin
            m_addr[k] = '0; m_be[k] = '0; m_wdata[k] = '0;
        end
        s_ack = 1'b0; s_resp = 1'b0; s_rdata = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_idle();
        m_req = 2'b11; m_be[0] = 4'hF; m_addr[0] = 32'h10;
        s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        checks++;
        if ({s_req_o, m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o, err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=000000",
                     {s_req_o, m0_ack_o, m1_ack_o, m0_resp_o, m1_resp_o, err_o});
        end
        checks++;
        if ({s_addr_bo, s_be_bo, m0_rdata_bo, m1_rdata_bo} !== '0) begin
            errors++;
            $display("FAIL reset_data got addr=%h be=%h rd0=%h rd1=%h exp all 0",
                     s_addr_bo, s_be_bo, m0_rdata_bo, m1_rdata_bo);
        end
        do_reset();
    endtask

    task automatic test_alternate();
        int          prev;
        logic [31:0] last_addr;
        do_reset();
        m_req = 2'b11; m_we = 2'b00;
        m_addr[0] = 32'h10; m_addr[1] = 32'h20;
        m_be[0] = 4'hF; m_be[1] = 4'hF;
        s_ack = 1'b1;
        prev = 0;
        last_addr = '0;
        for (int i = 0; i < 6; i++) begin
            s_resp  = (i > 0);
            s_rdata = (last_addr == 32'h10) ? DATA_M0 : DATA_M1;
            #1;
            checks++;
            if ({m1_ack_o, m0_ack_o} !== ((i % 2 == 1) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL alt_grant cyc=%0d got=%b exp_winner=m%0d", i, {m1_ack_o, m0_ack_o}, i % 2);
            end
            if (i > 0) begin
                checks++;
                if ({m1_resp_o, m0_resp_o} !== ((prev == 1) ? 2'b10 : 2'b01) ||
                    ((prev == 0) ? m0_rdata_bo : m1_rdata_bo) !== ((prev == 0) ? DATA_M0 : DATA_M1) ||
                    ((prev == 0) ? m1_rdata_bo : m0_rdata_bo) !== 32'h0) begin
                    errors++;
                    $display("FAIL alt_route cyc=%0d got resp=%b rd0=%h rd1=%h exp owner=m%0d",
                             i, {m1_resp_o, m0_resp_o}, m0_rdata_bo, m1_rdata_bo, prev);
                end
            end
            prev = i % 2;
            last_addr = s_addr_bo;
            next_cycle();
        end
        m_req = 2'b00;
        s_resp = 1'b1;
        s_rdata = (last_addr == 32'h10) ? DATA_M0 : DATA_M1;
        #1;
        checks++;
        if ({m1_resp_o, m0_resp_o} !== 2'b10 || m1_rdata_bo !== DATA_M1) begin
            errors++;
            $display("FAIL alt_last got resp=%b rd1=%h exp resp=10 rd1=%h",
                     {m1_resp_o, m0_resp_o}, m1_rdata_bo, DATA_M1);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_write_stall();
        do_reset();
        m_req = 2'b11; m_we = 2'b01;
        m_addr[0] = 32'h3; m_be[0] = 4'b0001; m_wdata[0] = 32'h1234_5678;
        m_addr[1] = 32'h20; m_be[1] = 4'hF;
        s_ack = 1'b0;
        #1;
        checks++;
        if ({s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo, m1_ack_o, m0_ack_o} !==
            {1'b1, 1'b1, 32'h3, 4'b0001, 32'h1234_5678, 2'b00}) begin
            errors++;
            $display("FAIL wr_stall got req=%b we=%b addr=%h be=%b wd=%h ack=%b",
                     s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo, {m1_ack_o, m0_ack_o});
        end
        next_cycle();
        s_ack = 1'b1;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o} !== 2'b01) begin
            errors++;
            $display("FAIL wr_accept got=%b exp=01", {m1_ack_o, m0_ack_o});
        end
        next_cycle();
        m_req[0] = 1'b0;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o, s_we_o} !== 3'b100 || s_addr_bo !== 32'h20) begin
            errors++;
            $display("FAIL wr_then_m1 got ack=%b we=%b addr=%h", {m1_ack_o, m0_ack_o}, s_we_o, s_addr_bo);
        end
        next_cycle();
        m_req = 2'b00; s_ack = 1'b0;
        s_resp = 1'b1; s_rdata = 32'hCAFE_0003;
        #1;
        checks++;
        if ({m1_resp_o, m0_resp_o} !== 2'b10 || m1_rdata_bo !== 32'hCAFE_0003) begin
            errors++;
            $display("FAIL wr_no_entry got resp=%b rd1=%h exp resp=10", {m1_resp_o, m0_resp_o}, m1_rdata_bo);
        end
        next_cycle();
        s_resp = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL wr_err got=%b exp=0", err_o);
        end
        set_idle();
    endtask

    task automatic test_fifo_full();
        do_reset();
        m_req = 2'b01; m_we = 2'b00; m_addr[0] = 32'h40; m_be[0] = 4'hF;
        s_ack = 1'b1;
        for (int i = 0; i < RESP_DEPTH; i++) begin
            #1;
            checks++;
            if (m0_ack_o !== 1'b1) begin
                errors++;
                $display("FAIL full_fill n=%0d got=%b exp=1", i, m0_ack_o);
            end
            next_cycle();
        end
        #1;
        checks++;
        if ({s_req_o, m0_ack_o} !== 2'b00) begin
            errors++;
            $display("FAIL full_block got req=%b ack=%b exp 00", s_req_o, m0_ack_o);
        end
        next_cycle();
        m_req[1] = 1'b1; m_we[1] = 1'b1; m_addr[1] = 32'h44;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o, s_we_o} !== 3'b101) begin
            errors++;
            $display("FAIL full_write got ack=%b we=%b exp ack=10 we=1", {m1_ack_o, m0_ack_o}, s_we_o);
        end
        next_cycle();
        m_req[1] = 1'b0;
        s_resp = 1'b1; s_rdata = 32'h11;
        #1;
        checks++;
        if ({m0_resp_o, m0_ack_o} !== 2'b10) begin
            errors++;
            $display("FAIL full_pop_noacc got resp=%b ack=%b exp resp=1 ack=0", m0_resp_o, m0_ack_o);
        end
        next_cycle();
        s_resp = 1'b0;
        #1;
        checks++;
        if (m0_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL full_unblock got=%b exp=1", m0_ack_o);
        end
        next_cycle();
        m_req = 2'b00;
        for (int i = 0; i < RESP_DEPTH; i++) begin
            s_resp = 1'b1; s_rdata = 32'h100 + i;
            #1;
            checks++;
            if ({m1_resp_o, m0_resp_o} !== 2'b01 || m0_rdata_bo !== 32'h100 + i) begin
                errors++;
                $display("FAIL full_drain n=%0d got resp=%b rd0=%h", i, {m1_resp_o, m0_resp_o}, m0_rdata_bo);
            end
            next_cycle();
        end
        s_resp = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL full_err got=%b exp=0", err_o);
        end
        set_idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        m_req = 2'b10; m_we = 2'b00; m_addr[1] = 32'h20; m_addr[0] = 32'h10;
        s_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({m1_ack_o, m0_ack_o} !== 2'b10) begin
                errors++;
                $display("FAIL b2b_fill n=%0d got=%b exp=10", i, {m1_ack_o, m0_ack_o});
            end
            next_cycle();
        end
        m_req = 2'b01; s_resp = 1'b1; s_rdata = 32'h21;
        #1;
        checks++;
        if ({m0_ack_o, m1_resp_o, m0_resp_o} !== 3'b110 || m1_rdata_bo !== 32'h21) begin
            errors++;
            $display("FAIL b2b_pushpop got ack0=%b resp=%b rd1=%h", m0_ack_o, {m1_resp_o, m0_resp_o}, m1_rdata_bo);
        end
        next_cycle();
        m_req = 2'b00; s_rdata = 32'h22;
        #1;
        checks++;
        if ({m1_resp_o, m0_resp_o} !== 2'b10 || m1_rdata_bo !== 32'h22) begin
            errors++;
            $display("FAIL b2b_second got resp=%b rd1=%h exp resp=10", {m1_resp_o, m0_resp_o}, m1_rdata_bo);
        end
        next_cycle();
        s_rdata = 32'h23;
        #1;
        checks++;
        if ({m1_resp_o, m0_resp_o} !== 2'b01 || m0_rdata_bo !== 32'h23) begin
            errors++;
            $display("FAIL b2b_third got resp=%b rd0=%h exp resp=01", {m1_resp_o, m0_resp_o}, m0_rdata_bo);
        end
        next_cycle();
        s_resp = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_err got=%b exp=0", err_o);
        end
        set_idle();
    endtask

    task automatic test_spurious();
        do_reset();
        s_resp = 1'b1; s_rdata = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({m1_resp_o, m0_resp_o, err_o} !== 3'b000 || {m0_rdata_bo, m1_rdata_bo} !== 64'h0) begin
            errors++;
            $display("FAIL spur_drop got resp=%b err=%b rd0=%h rd1=%h",
                     {m1_resp_o, m0_resp_o}, err_o, m0_rdata_bo, m1_rdata_bo);
        end
        next_cycle();
        s_resp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (err_o !== 1'b1) begin
                errors++;
                $display("FAIL spur_sticky n=%0d got=%b exp=1", i, err_o);
            end
            next_cycle();
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL spur_clear got=%b exp=0", err_o);
        end
        do_reset();
    endtask

    task automatic test_async_reset();
        do_reset();
        m_req = 2'b01; m_we = 2'b00; m_addr[0] = 32'h10; m_addr[1] = 32'h20;
        s_ack = 1'b1;
        next_cycle();
        m_req = 2'b11;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o} !== 2'b10) begin
            errors++;
            $display("FAIL areset_prio_pre got=%b exp=10", {m1_ack_o, m0_ack_o});
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_req_o, m1_ack_o, m0_ack_o, err_o} !== 4'b0 || s_addr_bo !== 32'h0) begin
            errors++;
            $display("FAIL areset_outputs got req=%b ack=%b err=%b addr=%h",
                     s_req_o, {m1_ack_o, m0_ack_o}, err_o, s_addr_bo);
        end
        set_idle();
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        m_req = 2'b11; m_addr[0] = 32'h10; m_addr[1] = 32'h20;
        s_ack = 1'b1; s_resp = 1'b1; s_rdata = 32'h5555_0000;
        #1;
        checks++;
        if ({m1_ack_o, m0_ack_o, m1_resp_o, m0_resp_o} !== 4'b0100) begin
            errors++;
            $display("FAIL areset_first got ack=%b resp=%b exp ack=01 resp=00",
                     {m1_ack_o, m0_ack_o}, {m1_resp_o, m0_resp_o});
        end
        next_cycle();
        set_idle();
        #1;
        checks++;
        if (err_o !== 1'b1) begin
            errors++;
            $display("FAIL areset_inflight_err got=%b exp=1", err_o);
        end
        do_reset();
    endtask

    // Reference model: pending reads are a queue of master numbers; a master
    // may be granted if it requests and is writing or the queue has room.
    task automatic test_random();
        int          prio;
        int          mq[$];
        logic        merr;
        logic [1:0]  elig;
        int          w, h;
        logic        gv, acc, pop;
        logic [69:0] exp_slave;
        logic [1:0]  exp_ack, exp_resp;
        logic [31:0] exp_rd [2];
        do_reset();
        prio = 0;
        mq.delete();
        merr = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            m_req = 2'($urandom_range(0, 3));
            m_we  = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
            for (int k = 0; k < 2; k++) begin
                m_addr[k]  = $urandom;
                m_be[k]    = 4'($urandom);
                m_wdata[k] = $urandom;
            end
            s_ack   = ($urandom_range(0, 3) != 0);
            s_resp  = ($urandom_range(0, 2) == 0) && (mq.size() > 0 || $urandom_range(0, 60) == 0);
            s_rdata = $urandom;
            #1;
            for (int k = 0; k < 2; k++)
                elig[k] = m_req[k] && (m_we[k] || mq.size() < RESP_DEPTH);
            gv = |elig;
            if (elig == 2'b11) w = prio;
            else if (elig[1]) w = 1;
            else w = 0;
            exp_slave = gv ? {1'b1, m_we[w], m_addr[w], m_be[w], m_wdata[w]} : '0;
            acc = gv && s_ack;
            exp_ack = '0;
            if (acc) exp_ack[w] = 1'b1;
            pop = s_resp && mq.size() > 0;
            h = pop ? mq[0] : 0;
            exp_resp = '0;
            exp_rd[0] = '0; exp_rd[1] = '0;
            if (pop) begin
                exp_resp[h] = 1'b1;
                exp_rd[h]   = s_rdata;
            end
            checks++;
            if ({s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo} !== exp_slave) begin
                errors++;
                $display("FAIL rnd_slave cyc=%0d got=%h exp=%h", cyc,
                         {s_req_o, s_we_o, s_addr_bo, s_be_bo, s_wdata_bo}, exp_slave);
            end
            checks++;
            if ({m1_ack_o, m0_ack_o} !== exp_ack || {m1_resp_o, m0_resp_o} !== exp_resp) begin
                errors++;
                $display("FAIL rnd_ack_resp cyc=%0d got ack=%b resp=%b exp ack=%b resp=%b", cyc,
                         {m1_ack_o, m0_ack_o}, {m1_resp_o, m0_resp_o}, exp_ack, exp_resp);
            end
            checks++;
            if (m0_rdata_bo !== exp_rd[0] || m1_rdata_bo !== exp_rd[1] || err_o !== merr) begin
                errors++;
                $display("FAIL rnd_rdata cyc=%0d got rd0=%h rd1=%h err=%b exp rd0=%h rd1=%h err=%b", cyc,
                         m0_rdata_bo, m1_rdata_bo, err_o, exp_rd[0], exp_rd[1], merr);
            end
            if (s_resp && mq.size() == 0) merr = 1'b1;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                if (!m_we[w]) mq.push_back(w);
                prio = 1 - w;
            end
            next_cycle();
        end
        set_idle();
    endtask

    initial begin
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_alternate();
        test_write_stall();
        test_fifo_full();
        test_back_to_back();
        test_spurious();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
